// File: rtl/answer_checker_pkg.sv
// answer_checker_pkg: shared definitions for the DCACHE answer checker.
//   state_t : checker state encoding (also driven onto the state port)
//   clog2   : ceiling log2 with a floor of 1, so index ports never collapse
//             to zero width when only one answer is configured
package answer_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/answer_table.sv
// answer_table: golden answer register array.
//   clk     : clock
//   we      : write strobe
//   wr_idx  : write entry index (out-of-range indices are dropped)
//   wr_data : value written
//   rd_idx  : combinational read index
//   rd_data : entry at rd_idx (pre-write value during a write cycle)
module answer_table #(
  parameter int DATA_W  = 32,
  parameter int NUM_ANS = 32,
  parameter int IDX_W   = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_ANS];

  // Data storage only; no reset so the table survives a checker restart.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wr_idx} < (IDX_W+1)'(NUM_ANS)))
      mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/answer_checker.sv
// answer_checker: snoops the DCACHE write port and compares every write that
// lands in the answer window against a loadable golden table.
//   clk, rst        : clock, synchronous active-high reset
//   addr/data/wen   : snooped DCACHE word address, write data, write enable
//   ld_en/ld_idx/ld_data : golden-table load port (honoured in IDLE only)
//   error_num       : mismatches so far (saturating)
//   duration        : cycles since reset release (saturating, frozen at end)
//   finish          : every answer received
//   timeout         : TIMEOUT_CYC elapsed before finish
//   state           : checker state for debug
module answer_checker
  import answer_checker_pkg::*;
#(
  parameter int                ADDR_W      = 30,
  parameter int                DATA_W      = 32,
  parameter int                NUM_ANS     = 32,
  parameter logic [ADDR_W-1:0] ANS_BASE    = 30'h0000_0040,
  parameter int                ORDERED     = 1,
  parameter int                ERR_W       = 8,
  parameter int                DUR_W       = 16,
  parameter int                TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data,
  input  logic                       wen,
  input  logic                       ld_en,
  input  logic [clog2(NUM_ANS)-1:0]  ld_idx,
  input  logic [DATA_W-1:0]          ld_data,
  output logic [ERR_W-1:0]           error_num,
  output logic [DUR_W-1:0]           duration,
  output logic                       finish,
  output logic                       timeout,
  output logic [1:0]                 state
);

  localparam int IDX_W = clog2(NUM_ANS);
  localparam int CNT_W = clog2(NUM_ANS + 1);

  // One extra bit so the window top cannot wrap at the end of the address space.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, ANS_BASE};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(NUM_ANS);

  function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [DUR_W-1:0] sat_dur(input logic [DUR_W-1:0] v);
    return (&v) ? v : v + DUR_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_ANS-1:0] seen_q, seen_d;
  logic               finish_q, timeout_q;

  logic               in_win;
  logic               bad;
  logic [ADDR_W-1:0]  off;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  rd_data;

  assign off    = addr - ANS_BASE;
  assign idx    = off[IDX_W-1:0];
  assign in_win = wen && ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
  // Sequence mode reads the entry the next write is expected to carry.
  assign rd_idx = (ORDERED != 0) ? cnt_q[IDX_W-1:0] : idx;

  answer_table #(
    .DATA_W  (DATA_W),
    .NUM_ANS (NUM_ANS),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .we      (ld_en && (state_q == ST_IDLE)),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    dur_d   = dur_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    bad     = 1'b0;
    case (state_q)
      ST_IDLE, ST_CHECK: begin
        dur_d = sat_dur(dur_q);
        if (in_win) begin
          state_d = ST_CHECK;
          if (ORDERED != 0) begin
            bad   = (off != ADDR_W'(cnt_q)) || (data != rd_data);
            cnt_d = cnt_q + CNT_W'(1);
          end else if (seen_q[idx]) begin
            bad = 1'b1;
          end else begin
            bad         = (data != rd_data);
            seen_d[idx] = 1'b1;
            cnt_d       = cnt_q + CNT_W'(1);
          end
          if (bad) err_d = sat_err(err_q);
        end
        // Completion outranks a timeout landing on the same edge.
        if (cnt_d == CNT_W'(NUM_ANS))
          state_d = ST_DONE;
        else if (dur_q == DUR_W'(TIMEOUT_CYC - 1))
          state_d = ST_TIMEOUT;
      end
      default: ;
    endcase
  end

  // Control state and counters; all outputs come straight from these flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      err_q     <= '0;
      dur_q     <= '0;
      cnt_q     <= '0;
      seen_q    <= '0;
      finish_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      dur_q     <= dur_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      finish_q  <= (state_d == ST_DONE);
      timeout_q <= (state_d == ST_TIMEOUT);
    end
  end

  assign error_num = err_q;
  assign duration  = dur_q;
  assign finish    = finish_q;
  assign timeout   = timeout_q;
  assign state     = state_q;

endmodule

// File: tb/tb_answer_checker.sv
// tb_answer_checker: two checker instances (sequence mode and address-indexed
// mode with a 2-bit error counter and a short timeout) driven by directed
// vectors, checked every cycle against a behavioural model plus literal
// expectations at the interesting points.
module tb_answer_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a     [2];
  logic [29:0] addr_a    [2];
  logic [31:0] data_a    [2];
  logic        wen_a     [2];
  logic        ld_en_a   [2];
  logic [1:0]  ld_idx_a  [2];
  logic [31:0] ld_data_a [2];

  logic [7:0]  err_o;
  logic [1:0]  err_u;
  logic [15:0] dur_o, dur_u;
  logic        fin_o, fin_u, to_o, to_u;
  logic [1:0]  st_o, st_u;

  answer_checker #(
    .ADDR_W(30), .DATA_W(32), .NUM_ANS(4), .ANS_BASE(30'h40),
    .ORDERED(1), .ERR_W(8), .DUR_W(16), .TIMEOUT_CYC(1000)
  ) dut_o (
    .clk(clk), .rst(rst_a[0]), .addr(addr_a[0]), .data(data_a[0]), .wen(wen_a[0]),
    .ld_en(ld_en_a[0]), .ld_idx(ld_idx_a[0]), .ld_data(ld_data_a[0]),
    .error_num(err_o), .duration(dur_o), .finish(fin_o), .timeout(to_o), .state(st_o)
  );

  answer_checker #(
    .ADDR_W(30), .DATA_W(32), .NUM_ANS(4), .ANS_BASE(30'h40),
    .ORDERED(0), .ERR_W(2), .DUR_W(16), .TIMEOUT_CYC(100)
  ) dut_u (
    .clk(clk), .rst(rst_a[1]), .addr(addr_a[1]), .data(data_a[1]), .wen(wen_a[1]),
    .ld_en(ld_en_a[1]), .ld_idx(ld_idx_a[1]), .ld_data(ld_data_a[1]),
    .error_num(err_u), .duration(dur_u), .finish(fin_u), .timeout(to_u), .state(st_u)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: unbounded error tally clamped on output, set of seen
  // answer slots, count of answers accepted, and plain finished/timed-out flags.
  logic [31:0] m_gold [2][4];
  int          m_err  [2];
  int          m_dur  [2];
  int          m_got  [2];
  bit          m_seen [2][4];
  bit          m_busy [2];
  bit          m_fin  [2];
  bit          m_to   [2];
  int          m_pos;
  bit          m_was_idle;

  function automatic int err_max(input int d);
    return (d == 0) ? 255 : 3;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 1000 : 100;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_a[d]) begin
        m_err[d] = 0; m_dur[d] = 0; m_got[d] = 0;
        m_busy[d] = 0; m_fin[d] = 0; m_to[d] = 0;
        for (int i = 0; i < 4; i++) m_seen[d][i] = 0;
      end else if (!m_fin[d] && !m_to[d]) begin
        m_was_idle = !m_busy[d];
        if (wen_a[d] && addr_a[d] >= 30'h40 && addr_a[d] < 30'h44) begin
          m_pos = int'(addr_a[d]) - 64;
          m_busy[d] = 1;
          if (d == 0) begin
            if (m_pos != m_got[d] || data_a[d] != m_gold[d][m_got[d]]) m_err[d]++;
            m_got[d]++;
          end else if (m_seen[d][m_pos]) begin
            m_err[d]++;
          end else begin
            if (data_a[d] != m_gold[d][m_pos]) m_err[d]++;
            m_seen[d][m_pos] = 1;
            m_got[d]++;
          end
        end
        if (m_was_idle && ld_en_a[d]) m_gold[d][ld_idx_a[d]] = ld_data_a[d];
        if (m_got[d] == 4) m_fin[d] = 1;
        else if (m_dur[d] == tmo_of(d) - 1) m_to[d] = 1;
        if (m_dur[d] < 65535) m_dur[d]++;
      end
    end
  end

  function automatic logic [31:0] m_state(input int d);
    return m_fin[d] ? 32'd2 : m_to[d] ? 32'd3 : m_busy[d] ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] m_errv(input int d);
    return (m_err[d] > err_max(d)) ? 32'(err_max(d)) : 32'(m_err[d]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("o.error_num", 32'(err_o), m_errv(0));
      cmp("o.duration",  32'(dur_o), 32'(m_dur[0]));
      cmp("o.finish",    32'(fin_o), 32'(m_fin[0]));
      cmp("o.timeout",   32'(to_o),  32'(m_to[0]));
      cmp("o.state",     32'(st_o),  m_state(0));
      cmp("u.error_num", 32'(err_u), m_errv(1));
      cmp("u.duration",  32'(dur_u), 32'(m_dur[1]));
      cmp("u.finish",    32'(fin_u), 32'(m_fin[1]));
      cmp("u.timeout",   32'(to_u),  32'(m_to[1]));
      cmp("u.state",     32'(st_u),  m_state(1));
    end
  end

  logic [31:0] gold_v [4];
  logic [29:0] seq_a  [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    wen_a[d] = 0; addr_a[d] = '0; data_a[d] = '0;
    ld_en_a[d] = 0; ld_idx_a[d] = '0; ld_data_a[d] = '0;
  endtask

  task automatic wr(input int d, input logic [29:0] a, input logic [31:0] v);
    wen_a[d] = 1; addr_a[d] = a; data_a[d] = v;
  endtask

  task automatic load(input int d, input int i, input logic [31:0] v);
    ld_en_a[d] = 1; ld_idx_a[d] = 2'(i); ld_data_a[d] = v;
  endtask

  task automatic restart(input int d);
    idle(d);
    rst_a[d] = 1;
    tick();
    rst_a[d] = 0;
  endtask

  initial begin
    gold_v[0] = 32'h11; gold_v[1] = 32'h22; gold_v[2] = 32'h33; gold_v[3] = 32'h44;
    idle(0); idle(1);
    rst_a[0] = 1; rst_a[1] = 1;
    tick(); tick();
    chk_en = 1;
    cmp("reset.state", 32'(st_o), 32'd0);
    cmp("reset.error_num", 32'(err_o), 32'd0);

    // Sequence mode, all correct, writes at cycles 20/25/30/35.
    rst_a[0] = 0;
    for (int c = 0; c < 40; c++) begin
      idle(0);
      if (c < 4) load(0, c, gold_v[c]);
      if (c >= 20 && c <= 35 && (c - 20) % 5 == 0)
        wr(0, 30'h40 + 30'((c - 20) / 5), gold_v[(c - 20) / 5]);
      tick();
      if (c == 34) cmp("t1.finish_early", 32'(fin_o), 32'd0);
      if (c == 35) begin
        cmp("t1.finish", 32'(fin_o), 32'd1);
        cmp("t1.error_num", 32'(err_o), 32'd0);
        cmp("t1.duration", 32'(dur_o), 32'd36);
        cmp("t1.state", 32'(st_o), 32'd2);
      end
    end
    cmp("t1.duration_frozen", 32'(dur_o), 32'd36);

    // Sequence mode, out-of-order addresses with per-address data.
    restart(0);
    seq_a[0] = 30'h40; seq_a[1] = 30'h42; seq_a[2] = 30'h41; seq_a[3] = 30'h43;
    for (int i = 0; i < 4; i++) begin
      wr(0, seq_a[i], gold_v[int'(seq_a[i]) - 64]);
      tick();
    end
    idle(0);
    cmp("t2.error_num", 32'(err_o), 32'd2);
    cmp("t2.finish", 32'(fin_o), 32'd1);

    // Mid-check reset, then a clean replay with the retained table.
    restart(0);
    wr(0, 30'h40, 32'h11); tick();
    wr(0, 30'h41, 32'h55); tick();
    idle(0);
    cmp("t5.error_pre", 32'(err_o), 32'd1);
    rst_a[0] = 1; tick();
    cmp("t5.error_rst", 32'(err_o), 32'd0);
    cmp("t5.duration_rst", 32'(dur_o), 32'd0);
    cmp("t5.state_rst", 32'(st_o), 32'd0);
    rst_a[0] = 0;
    for (int i = 0; i < 4; i++) begin
      wr(0, 30'h40 + 30'(i), gold_v[i]);
      tick();
    end
    idle(0);
    cmp("t5.finish", 32'(fin_o), 32'd1);
    cmp("t5.error_num", 32'(err_o), 32'd0);
    rst_a[0] = 1;

    // Address-indexed mode with a duplicate write.
    rst_a[1] = 0;
    for (int c = 0; c < 4; c++) begin
      load(1, c, gold_v[c]);
      tick();
    end
    idle(1);
    wr(1, 30'h43, 32'h44); tick();
    wr(1, 30'h41, 32'h22); tick();
    wr(1, 30'h41, 32'h99); tick();
    wr(1, 30'h40, 32'h11); tick();
    cmp("t3.finish_early", 32'(fin_u), 32'd0);
    wr(1, 30'h42, 32'h33); tick();
    idle(1);
    cmp("t3.finish", 32'(fin_u), 32'd1);
    cmp("t3.error_num", 32'(err_u), 32'd1);

    // Timeout with only out-of-window traffic.
    restart(1);
    for (int c = 0; c < 110; c++) begin
      wr(1, 30'h10, 32'h5);
      tick();
      if (c == 98) cmp("t4.timeout_early", 32'(to_u), 32'd0);
      if (c == 99) begin
        cmp("t4.timeout", 32'(to_u), 32'd1);
        cmp("t4.finish", 32'(fin_u), 32'd0);
        cmp("t4.duration", 32'(dur_u), 32'd100);
        cmp("t4.state", 32'(st_u), 32'd3);
      end
    end
    idle(1);
    cmp("t4.duration_held", 32'(dur_u), 32'd100);

    // Load coincident with the first write: compare sees the old entry.
    restart(1);
    load(1, 0, 32'hAA);
    wr(1, 30'h40, 32'h11);
    tick();
    idle(1);
    cmp("t6.coincident_err", 32'(err_u), 32'd0);
    cmp("t6.coincident_state", 32'(st_u), 32'd1);
    for (int i = 1; i < 4; i++) begin
      wr(1, 30'h40 + 30'(i), gold_v[i]);
      tick();
    end
    idle(1);
    cmp("t6.finish", 32'(fin_u), 32'd1);

    // Four wrong answers against a 2-bit counter (entry 0 now holds 0xAA).
    restart(1);
    wr(1, 30'h40, 32'h11); tick();
    for (int i = 1; i < 4; i++) begin
      wr(1, 30'h40 + 30'(i), 32'h0);
      tick();
    end
    idle(1);
    cmp("t6.error_sat", 32'(err_u), 32'd3);
    cmp("t6.finish_sat", 32'(fin_u), 32'd1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
